// File: rtl/turf_uart_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  turf_uart_pkg : shared types and sampling constants for the TURF UART RX
//  Revision 1.0
// ============================================================================
package turf_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Three samples around the middle of each 16-tick bit period
    localparam logic [3:0] SAMPLE_A = 4'd6;
    localparam logic [3:0] SAMPLE_B = 4'd7;
    localparam logic [3:0] SAMPLE_C = 4'd8;
    localparam logic [3:0] CNT_LAST = 4'd15;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/turf_uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  turf_uart_rx_if : AXI-Stream style byte output of the UART receiver
//  Revision 1.0
// ============================================================================
interface turf_uart_rx_if;
    logic [7:0] tdata;
    logic [1:0] tuser;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/turf_uart_rx_frac_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  frac_tick_gen : fractional accumulator producing a one-clk tick per carry
//  Revision 1.0
// ============================================================================
module frac_tick_gen #(
    parameter int ACC_BITS = 10,
    parameter int BAUD_ADD = 82
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam logic [ACC_BITS:0] c_add = (ACC_BITS+1)'(BAUD_ADD);

    logic [ACC_BITS:0] r_acc;

    // Carry bit is cleared every cycle, so it can be high for one clk only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[ACC_BITS-1:0]} + c_add;
        end
    end

    assign tick = r_acc[ACC_BITS];
endmodule
`default_nettype wire

// File: rtl/turf_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  turf_uart_rx : 8N1 UART receiver, 16x oversampled, 2-of-3 majority vote
//  Revision 1.0
// ============================================================================
module turf_uart_rx
    import turf_uart_pkg::*;
#(
    parameter int ACC_BITS = 10,
    parameter int BAUD_ADD = 82
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    turf_uart_rx_if.master        m_axis,
    output logic                  overrun
);
    logic       r_rx_meta;
    logic       r_rx_s;
    logic       w_tick;
    rx_state_t  r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic [1:0] r_smp;
    logic [7:0] r_tdata;
    logic [1:0] r_tuser;
    logic       r_tvalid;
    logic       r_overrun;
    logic       w_maj;
    logic       w_done;
    logic       w_ferr;
    logic       w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    frac_tick_gen #(
        .ACC_BITS (ACC_BITS),
        .BAUD_ADD (BAUD_ADD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_maj    = majority3({r_smp, r_rx_s});
    assign w_done   = w_tick && (r_state == ST_STOP) && (r_cnt == SAMPLE_C);
    assign w_ferr   = ~w_maj;
    assign w_accept = !r_tvalid || m_axis.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_smp     <= '0;
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_tick) begin
                if (r_state == ST_IDLE) begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == SAMPLE_A) r_smp[1] <= r_rx_s;
                    if (r_cnt == SAMPLE_B) r_smp[0] <= r_rx_s;
                    case (r_state)
                        ST_START: begin
                            if (r_cnt == SAMPLE_C && w_maj) begin
                                r_state <= ST_IDLE;
                            end else if (r_cnt == CNT_LAST) begin
                                r_state <= ST_DATA;
                                r_idx   <= '0;
                            end
                        end
                        ST_DATA: begin
                            if (r_cnt == SAMPLE_C) r_shift[r_idx] <= w_maj;
                            if (r_cnt == CNT_LAST) begin
                                if (r_idx == 3'd7) r_state <= ST_STOP;
                                else               r_idx   <= r_idx + 3'd1;
                            end
                        end
                        // Leave at mid-stop-bit so the next start edge is never missed
                        ST_STOP: begin
                            if (r_cnt == SAMPLE_C) r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end

            if (w_done) begin
                if (w_accept) begin
                    r_tdata  <= r_shift;
                    r_tuser  <= {w_ferr && (r_shift == 8'h00), w_ferr};
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tuser  = r_tuser;
    assign m_axis.tvalid = r_tvalid;
    assign overrun       = r_overrun;
endmodule
`default_nettype wire
